// File: rtl/imem_loader.sv
`default_nettype none
// ============================================================================
// Module   : imem_loader
// Purpose  : Unpacks a framed UART byte stream into 32-bit instruction RAM
//            writes and holds the CPU in reset until a verified image exists.
// Revision : 1.0
// ============================================================================
module imem_loader #(
    parameter int         MAX_WORDS      = 256,
    parameter logic [7:0] MAGIC          = 8'hA5,
    parameter int         TIMEOUT_CYCLES = 50000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [7:0]  rx_data,
    input  logic        rx_valid,
    input  logic        reload,
    output logic        wr_en,
    output logic [31:0] wr_addr,
    output logic [31:0] wr_data,
    output logic        cpu_hold,
    output logic        done,
    output logic        error,
    output logic [15:0] word_count
);

    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

    typedef enum logic [2:0] {
        S_IDLE, S_LEN_HI, S_LEN_LO, S_DATA, S_CHK, S_DONE, S_ERR
    } state_t;

    state_t        r_state, w_next;
    logic [TW-1:0] r_tmo;
    logic [7:0]    r_len_hi, r_chk, r_word_idx;
    logic [15:0]   r_len;
    logic [1:0]    r_byte_idx;
    logic [23:0]   r_asm;

    logic          w_timed, w_tmo_hit, w_len_bad, w_word_done, w_last_word;
    logic          w_start, w_reload;
    logic [15:0]   w_len;

    assign w_len       = {r_len_hi, rx_data};
    assign w_len_bad   = (w_len == 16'd0) || (w_len > 16'(MAX_WORDS));
    assign w_timed     = (r_state == S_LEN_HI) || (r_state == S_LEN_LO) ||
                         (r_state == S_DATA)   || (r_state == S_CHK);
    assign w_tmo_hit   = w_timed && !rx_valid && (r_tmo == TW'(TIMEOUT_CYCLES - 1));
    assign w_word_done = (r_state == S_DATA) && rx_valid && (r_byte_idx == 2'd3);
    assign w_last_word = ((word_count + 16'd1) == r_len);
    assign w_reload    = reload && ((r_state == S_DONE) || (r_state == S_ERR));
    // reload beats a simultaneous byte, so a MAGIC arriving with it is dropped
    assign w_start     = rx_valid && (rx_data == MAGIC) &&
                         ((r_state == S_IDLE) || ((r_state == S_ERR) && !reload));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) r_state <= S_IDLE;
        else       r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            S_IDLE:   if (w_start) w_next = S_LEN_HI;
            S_LEN_HI: if (rx_valid) w_next = S_LEN_LO;
                      else if (w_tmo_hit) w_next = S_ERR;
            S_LEN_LO: if (rx_valid) w_next = w_len_bad ? S_ERR : S_DATA;
                      else if (w_tmo_hit) w_next = S_ERR;
            S_DATA:   if (w_word_done && w_last_word) w_next = S_CHK;
                      else if (w_tmo_hit) w_next = S_ERR;
            S_CHK:    if (rx_valid) w_next = (rx_data == r_chk) ? S_DONE : S_ERR;
                      else if (w_tmo_hit) w_next = S_ERR;
            S_DONE:   if (w_reload) w_next = S_IDLE;
            S_ERR:    if (w_reload) w_next = S_IDLE;
                      else if (w_start) w_next = S_LEN_HI;
            default:  w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_en      <= 1'b0;
            wr_addr    <= 32'd0;
            wr_data    <= 32'd0;
            cpu_hold   <= 1'b1;
            done       <= 1'b0;
            error      <= 1'b0;
            word_count <= 16'd0;
            r_tmo      <= '0;
            r_len_hi   <= 8'd0;
            r_len      <= 16'd0;
            r_chk      <= 8'd0;
            r_word_idx <= 8'd0;
            r_byte_idx <= 2'd0;
            r_asm      <= 24'd0;
        end else begin
            wr_en    <= 1'b0;
            done     <= (w_next == S_DONE);
            error    <= (w_next == S_ERR);
            cpu_hold <= (w_next != S_DONE);

            // counter stays 0 outside the framed states and restarts on every byte
            if (w_timed && !rx_valid && !w_tmo_hit) r_tmo <= r_tmo + TW'(1);
            else                                    r_tmo <= '0;

            if (w_reload) word_count <= 16'd0;

            if (w_start) begin
                r_chk      <= 8'd0;
                r_byte_idx <= 2'd0;
                r_word_idx <= 8'd0;
                word_count <= 16'd0;
            end

            if (rx_valid) begin
                unique case (r_state)
                    S_LEN_HI: begin
                        r_len_hi <= rx_data;
                        r_chk    <= r_chk ^ rx_data;
                    end
                    S_LEN_LO: begin
                        r_len <= w_len;
                        r_chk <= r_chk ^ rx_data;
                    end
                    S_DATA: begin
                        r_chk      <= r_chk ^ rx_data;
                        r_byte_idx <= r_byte_idx + 2'd1;
                        r_asm      <= {r_asm[15:0], rx_data};
                        if (r_byte_idx == 2'd3) begin
                            wr_en      <= 1'b1;
                            wr_addr    <= {22'd0, r_word_idx, 2'b00};
                            wr_data    <= {r_asm, rx_data};
                            r_word_idx <= r_word_idx + 8'd1;
                            word_count <= word_count + 16'd1;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_imem_loader.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : tb_imem_loader
// Purpose  : Self-checking bench for imem_loader against a frame-level model.
// Revision : 1.0
// ============================================================================
module tb_imem_loader;

    localparam int TMO = 200;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [7:0]  rx_data = 8'd0;
    logic        rx_valid = 1'b0;
    logic        reload = 1'b0;
    logic        wr_en;
    logic [31:0] wr_addr, wr_data;
    logic        cpu_hold, done, error;
    logic [15:0] word_count;

    int vectors = 0;
    int miscompares = 0;

    logic [7:0]  stim[$];
    logic [31:0] exp_addr[$], exp_data[$];
    logic [31:0] cap_addr[$], cap_data[$];
    int          exp_status;   // 1 = verified image, 2 = frame error
    logic        prev_wr = 1'b0;
    int          consec_seen = 0, misaligned = 0;

    imem_loader #(.MAX_WORDS(256), .MAGIC(8'hA5), .TIMEOUT_CYCLES(TMO)) dut (
        .clk(clk), .reset(reset), .rx_data(rx_data), .rx_valid(rx_valid),
        .reload(reload), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .cpu_hold(cpu_hold), .done(done), .error(error), .word_count(word_count)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (wr_en) begin
            cap_addr.push_back(wr_addr);
            cap_data.push_back(wr_data);
            if (prev_wr) consec_seen++;
            if (wr_addr[1:0] != 2'b00) misaligned++;
        end
        prev_wr = wr_en;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, vectors=%0d", vectors);
        $fatal(1, "watchdog");
    end

    // Frame-level reference: locate MAGIC, read the length, cut words, verify XOR.
    task automatic model_stream();
        int m = -1;
        int len;
        logic [7:0] x;
        exp_addr.delete(); exp_data.delete();
        exp_status = 0;
        for (int i = 0; i < stim.size(); i++)
            if (m < 0 && stim[i] == 8'hA5) m = i;
        if (m < 0) return;
        len = {stim[m+1], stim[m+2]};
        if (len == 0 || len > 256) begin
            exp_status = 2;
            return;
        end
        x = stim[m+1] ^ stim[m+2];
        for (int w = 0; w < len; w++) begin
            int b = m + 3 + 4 * w;
            exp_addr.push_back(32'(w) * 32'd4);
            exp_data.push_back({stim[b], stim[b+1], stim[b+2], stim[b+3]});
            x = x ^ stim[b] ^ stim[b+1] ^ stim[b+2] ^ stim[b+3];
        end
        exp_status = (stim[m + 3 + 4 * len] == x) ? 1 : 2;
    endtask

    task automatic build_frame(input int len, input bit bad);
        logic [7:0] x, b;
        stim.delete();
        stim.push_back(8'hA5);
        stim.push_back(len[15:8]);
        stim.push_back(len[7:0]);
        x = len[15:8] ^ len[7:0];
        for (int i = 0; i < 4 * len; i++) begin
            b = 8'($urandom);
            stim.push_back(b);
            x ^= b;
        end
        stim.push_back(bad ? (x ^ 8'h01) : x);
    endtask

    task automatic send_byte(input logic [7:0] b, input int gap);
        @(negedge clk);
        rx_data  = b;
        rx_valid = 1'b1;
        @(negedge clk);
        rx_valid = 1'b0;
        repeat (gap - 2) @(negedge clk);
    endtask

    task automatic pulse_reload();
        @(negedge clk);
        reload = 1'b1;
        @(negedge clk);
        reload = 1'b0;
    endtask

    task automatic run_frame(input string name, input int gmax);
        pulse_reload();
        cap_addr.delete(); cap_data.delete();
        model_stream();
        foreach (stim[i]) send_byte(stim[i], $urandom_range(2, gmax));
        repeat (4) @(negedge clk);
        vectors++;
        if (cap_addr.size() != exp_addr.size()) begin
            miscompares++;
            $display("FAIL %s nwrites: got %0d want %0d", name, cap_addr.size(), exp_addr.size());
        end
        for (int i = 0; i < exp_addr.size() && i < cap_addr.size(); i++) begin
            vectors++;
            if (cap_addr[i] !== exp_addr[i] || cap_data[i] !== exp_data[i]) begin
                miscompares++;
                $display("FAIL %s write%0d: got %h/%h want %h/%h", name, i,
                         cap_addr[i], cap_data[i], exp_addr[i], exp_data[i]);
            end
        end
        vectors++;
        if (done !== (exp_status == 1) || error !== (exp_status == 2) ||
            cpu_hold !== (exp_status != 1) || word_count !== 16'(exp_addr.size())) begin
            miscompares++;
            $display("FAIL %s status: got done=%b err=%b hold=%b wc=%0d want status=%0d wc=%0d",
                     name, done, error, cpu_hold, word_count, exp_status, exp_addr.size());
        end
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        vectors += 7;
        if (cpu_hold !== 1'b1) begin miscompares++; $display("FAIL reset cpu_hold: got %b want 1", cpu_hold); end
        if (wr_en !== 1'b0) begin miscompares++; $display("FAIL reset wr_en: got %b want 0", wr_en); end
        if (wr_addr !== 32'd0) begin miscompares++; $display("FAIL reset wr_addr: got %h want 0", wr_addr); end
        if (wr_data !== 32'd0) begin miscompares++; $display("FAIL reset wr_data: got %h want 0", wr_data); end
        if (done !== 1'b0) begin miscompares++; $display("FAIL reset done: got %b want 0", done); end
        if (error !== 1'b0) begin miscompares++; $display("FAIL reset error: got %b want 0", error); end
        if (word_count !== 16'd0) begin miscompares++; $display("FAIL reset word_count: got %0d want 0", word_count); end
    endtask

    task automatic test_basic_frame();
        stim = '{8'hA5, 8'h00, 8'h02, 8'h08, 8'h00, 8'h00, 8'h03,
                 8'h20, 8'h0D, 8'h00, 8'h08, 8'h2C};
        run_frame("basic", 4);
        vectors++;
        if (cap_data.size() != 2 || cap_data[0] !== 32'h08000003 || cap_data[1] !== 32'h200D0008) begin
            miscompares++;
            $display("FAIL basic literal: got %0d writes want 08000003,200D0008", cap_data.size());
        end
    endtask

    task automatic test_bad_chk();
        stim = '{8'hA5, 8'h00, 8'h02, 8'h08, 8'h00, 8'h00, 8'h03,
                 8'h20, 8'h0D, 8'h00, 8'h08, 8'h2D};
        run_frame("badchk", 3);
        send_byte(8'hA5, 2);
        vectors++;
        if (error !== 1'b0 || cpu_hold !== 1'b1) begin
            miscompares++;
            $display("FAIL err_restart: got err=%b hold=%b want err=0 hold=1", error, cpu_hold);
        end
        send_byte(8'h00, 2);
        send_byte(8'h00, 2);
        vectors++;
        if (error !== 1'b1) begin
            miscompares++;
            $display("FAIL err_restart_len0: got err=%b want 1", error);
        end
    endtask

    task automatic test_junk();
        stim = '{8'h13, 8'hFF, 8'hA5, 8'h00, 8'h01, 8'h00, 8'h00, 8'h00, 8'h08, 8'h09};
        run_frame("junk", 3);
    endtask

    task automatic test_len_edges();
        stim = '{8'hA5, 8'h00, 8'h00};
        run_frame("len0", 3);
        stim = '{8'hA5, 8'h01, 8'h01};
        run_frame("len257", 3);
        build_frame(256, 1'b0);
        run_frame("len256", 2);
        vectors++;
        if (cap_addr.size() == 0 || cap_addr[cap_addr.size()-1] !== 32'h3FC) begin
            miscompares++;
            $display("FAIL len256 last_addr: got %0d writes want last at 3FC", cap_addr.size());
        end
    endtask

    task automatic test_random();
        for (int n = 0; n < 10; n++) begin
            build_frame($urandom_range(1, 9), ($urandom_range(0, 3) == 0));
            run_frame($sformatf("rand%0d", n), 5);
        end
    endtask

    task automatic test_timeout();
        pulse_reload();
        cap_addr.delete(); cap_data.delete();
        send_byte(8'hA5, 2);
        send_byte(8'h00, 2);
        send_byte(8'h01, 2);
        send_byte(8'h08, 2);
        repeat (TMO + 2) @(negedge clk);
        vectors++;
        if (error !== 1'b1 || cap_addr.size() != 0) begin
            miscompares++;
            $display("FAIL timeout: got err=%b writes=%0d want err=1 writes=0", error, cap_addr.size());
        end
        pulse_reload();
        cap_addr.delete(); cap_data.delete();
        send_byte(8'hA5, 2);
        send_byte(8'h00, 2);
        send_byte(8'h01, TMO - 2);
        send_byte(8'h00, 2);
        send_byte(8'h00, 2);
        send_byte(8'h00, 2);
        send_byte(8'h08, 2);
        send_byte(8'h09, 3);
        vectors++;
        if (done !== 1'b1 || error !== 1'b0 || cap_addr.size() != 1) begin
            miscompares++;
            $display("FAIL near_timeout: got done=%b err=%b writes=%0d want done=1 err=0 writes=1",
                     done, error, cap_addr.size());
        end
    endtask

    task automatic test_reload();
        pulse_reload();
        @(negedge clk);
        vectors++;
        if (cpu_hold !== 1'b1 || done !== 1'b0 || error !== 1'b0 || word_count !== 16'd0) begin
            miscompares++;
            $display("FAIL reload: got hold=%b done=%b err=%b wc=%0d want 1 0 0 0",
                     cpu_hold, done, error, word_count);
        end
        stim = '{8'hA5, 8'h00, 8'h01, 8'h00, 8'h00, 8'h00, 8'h08, 8'h09};
        run_frame("pre_sim", 3);
        // reload with a MAGIC byte in the same cycle must drop the byte
        @(negedge clk);
        reload = 1'b1; rx_valid = 1'b1; rx_data = 8'hA5;
        @(negedge clk);
        reload = 1'b0; rx_valid = 1'b0;
        repeat (2) @(negedge clk);
        build_frame(2, 1'b0);
        run_frame("reload_wins", 3);
    endtask

    task automatic test_reset_mid_data();
        pulse_reload();
        cap_addr.delete(); cap_data.delete();
        send_byte(8'hA5, 2);
        send_byte(8'h00, 2);
        send_byte(8'h02, 2);
        send_byte(8'h11, 2);
        send_byte(8'h22, 2);
        @(negedge clk);
        rx_data = 8'h33; rx_valid = 1'b1;
        #2 reset = 1'b1;
        #1;
        vectors++;
        if (cpu_hold !== 1'b1 || wr_en !== 1'b0 || wr_addr !== 32'd0 || wr_data !== 32'd0 ||
            done !== 1'b0 || error !== 1'b0 || word_count !== 16'd0) begin
            miscompares++;
            $display("FAIL reset_mid: got hold=%b wr=%b addr=%h data=%h done=%b err=%b wc=%0d",
                     cpu_hold, wr_en, wr_addr, wr_data, done, error, word_count);
        end
        @(negedge clk);
        rx_valid = 1'b0;
        send_byte(8'h44, 2);
        reset = 1'b0;
        repeat (3) @(negedge clk);
        vectors++;
        if (cap_addr.size() != 0) begin
            miscompares++;
            $display("FAIL reset_mid writes: got %0d want 0", cap_addr.size());
        end
    endtask

    task automatic test_write_spacing();
        vectors++;
        if (consec_seen != 0 || misaligned != 0) begin
            miscompares++;
            $display("FAIL write_spacing: got consecutive=%0d misaligned=%0d want 0 0",
                     consec_seen, misaligned);
        end
    endtask

    initial begin
        test_reset();
        test_basic_frame();
        test_bad_chk();
        test_junk();
        test_len_edges();
        test_random();
        test_timeout();
        test_reload();
        test_reset_mid_data();
        test_write_spacing();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire
